mac_sequencer: RTL and testbench

//  Initiator side of the signed 8-bit MAC datapath. On start it fetches VEC_LEN

---
 rtl/mac_sequencer_pkg.sv | 34 +++
 rtl/mac_sequencer_if.sv | 38 +++
 rtl/mac_sequencer_requant.sv | 24 ++
 rtl/mac_sequencer.sv | 106 ++++++++++
 tb/tb_mac_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sequencer_pkg
//  Description : Shared widths, FSM state type and the acc-to-data saturator
//                for the MAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 26;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 26'sd127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -26'sd128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      return 8'sh7f;
    else if (v < SAT_MIN)
      return 8'sh80;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sequencer_if
//  Description : Control, operand-RAM, MAC and result signals of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_sequencer_if #(
  parameter int ADDR_W = 3
);
  import mac_sequencer_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data_a;
  logic signed [DATA_W-1:0] rd_data_b;
  logic signed [DATA_W-1:0] mac_in1;
  logic signed [DATA_W-1:0] mac_in2;
  logic                     mac_clr_n;
  logic signed [ACC_W-1:0]  mac_acc;
  logic signed [DATA_W-1:0] res;
  logic                     res_vld;
  logic                     res_rdy;

  modport master (
    input  start, rd_data_a, rd_data_b, mac_acc, res_rdy,
    output busy, done, rd_en, rd_addr, mac_in1, mac_in2, mac_clr_n, res, res_vld
  );

  modport slave (
    output start, rd_data_a, rd_data_b, mac_acc, res_rdy,
    input  busy, done, rd_en, rd_addr, mac_in1, mac_in2, mac_clr_n, res, res_vld
  );

endinterface
`default_nettype wire

// File: rtl/mac_sequencer_requant.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sequencer_requant
//  Description : Combinational requantiser: arithmetic right shift then
//                saturation of the accumulator to signed 8-bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_sequencer_requant
  import mac_sequencer_pkg::*;
#(
  parameter int OUT_SHIFT = 7
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);

  logic signed [ACC_W-1:0] w_shifted;

  // >>> on a signed operand floors toward -inf, so -1 stays -1
  assign w_shifted = acc >>> OUT_SHIFT;
  assign res       = sat_data(w_shifted);

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sequencer
//  Description : Fetches VEC_LEN operand pairs, streams them into the MAC and
//                returns the requantised dot product on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int VEC_LEN   = 8,
  parameter int ADDR_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  parameter int OUT_SHIFT = 7
) (
  input  logic             clk,
  input  logic             rst,
  mac_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(VEC_LEN - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDR_W-1:0]        r_idx;
  logic [ADDR_W-1:0]        w_next_idx;
  logic signed [DATA_W-1:0] r_res;
  logic                     r_res_vld;
  logic signed [DATA_W-1:0] w_requant;

  mac_sequencer_requant #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_requant (
    .acc (bus.mac_acc),
    .res (w_requant)
  );

  assign w_next_idx  = r_idx + ADDR_W'(1);
  assign bus.busy    = (r_state != IDLE);
  assign bus.res     = r_res;
  assign bus.res_vld = r_res_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= (r_state == STREAM) ? w_next_idx : '0;
      if (r_state == DRAIN) begin
        r_res     <= w_requant;
        r_res_vld <= 1'b1;
      end else if (r_state == RESULT && bus.res_rdy) begin
        r_res_vld <= 1'b0;
      end
    end
  end

  // RAM read for element k+1 is issued while element k feeds the MAC
  always_comb begin
    w_state_next  = r_state;
    bus.done      = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.mac_in1   = '0;
    bus.mac_in2   = '0;
    bus.mac_clr_n = 1'b1;
    case (r_state)
      IDLE: begin
        bus.mac_clr_n = 1'b0;
        if (bus.start)
          w_state_next = CLEAR;
      end
      CLEAR: begin
        bus.mac_clr_n = 1'b0;
        bus.rd_en     = 1'b1;
        w_state_next  = STREAM;
      end
      STREAM: begin
        bus.mac_in1 = bus.rd_data_a;
        bus.mac_in2 = bus.rd_data_b;
        if (r_idx == c_last_idx) begin
          w_state_next = DRAIN;
        end else begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = w_next_idx;
        end
      end
      DRAIN: begin
        w_state_next = RESULT;
      end
      RESULT: begin
        if (bus.res_rdy) begin
          bus.done     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_sequencer
//  Description : Two sequencer instances (VEC_LEN=4/SHIFT=0, VEC_LEN=8/SHIFT=7)
//                with behavioural RAMs and MAC, checked against a dot-product model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  localparam int VL0 = 4;
  localparam int SH0 = 0;
  localparam int VL1 = 8;
  localparam int SH1 = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start   [2];
  logic              res_rdy [2];
  logic              busy    [2];
  logic              done    [2];
  logic              rd_en   [2];
  logic              clr_n   [2];
  logic              res_vld [2];
  logic [9:0]        rd_addr [2];
  logic signed [7:0] res     [2];
  logic signed [7:0] mem_a   [2][8];
  logic signed [7:0] mem_b   [2][8];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int VL = (g == 0) ? VL0 : VL1;
    localparam int SH = (g == 0) ? SH0 : SH1;
    localparam int AW = (VL > 1) ? $clog2(VL) : 1;

    mac_sequencer_if #(.ADDR_W(AW)) bus ();
    logic signed [25:0] acc;
    logic signed [15:0] prod;

    mac_sequencer #(
      .VEC_LEN   (VL),
      .ADDR_W    (AW),
      .OUT_SHIFT (SH)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always_ff @(posedge clk) begin
      if (bus.rd_en) begin
        bus.rd_data_a <= mem_a[g][int'(bus.rd_addr)];
        bus.rd_data_b <= mem_b[g][int'(bus.rd_addr)];
      end
    end

    assign prod = bus.mac_in1 * bus.mac_in2;
    always_ff @(posedge clk) begin
      if (!bus.mac_clr_n) acc <= '0;
      else                acc <= acc + 26'(prod);
    end

    assign bus.mac_acc = acc;
    assign bus.start   = start[g];
    assign bus.res_rdy = res_rdy[g];
    assign busy[g]     = bus.busy;
    assign done[g]     = bus.done;
    assign rd_en[g]    = bus.rd_en;
    assign clr_n[g]    = bus.mac_clr_n;
    assign res_vld[g]  = bus.res_vld;
    assign res[g]      = bus.res;
    assign rd_addr[g]  = 10'(bus.rd_addr);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int vec_len(input int g);
    return (g == 0) ? VL0 : VL1;
  endfunction

  // dot product, floor-divided by 2^shift, clamped to the signed 8-bit range
  function automatic int model(input int g);
    longint sum = 0;
    longint div;
    longint q;
    int sh = (g == 0) ? SH0 : SH1;
    for (int k = 0; k < vec_len(g); k++)
      sum += longint'(mem_a[g][k]) * longint'(mem_b[g][k]);
    div = longint'(1) << sh;
    if (sum >= 0) q = sum / div;
    else          q = -((-sum + div - 1) / div);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic fill(input int g, input int mode);
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0: begin mem_a[g][k] = 8'(k + 1); mem_b[g][k] = 8'sd1; end
        1: begin mem_a[g][k] = 8'sd127;   mem_b[g][k] = 8'sd127; end
        2: begin mem_a[g][k] = -8'sd128;  mem_b[g][k] = 8'sd127; end
        3: begin mem_a[g][k] = (k == 0) ? -8'sd1 : 8'sd0; mem_b[g][k] = (k == 0) ? 8'sd1 : 8'sd0; end
        default: begin
          mem_a[g][k] = 8'($urandom_range(0, 255));
          mem_b[g][k] = 8'($urandom_range(0, 255));
        end
      endcase
    end
  endtask

  // one start pulse, full run, rdy held low for hold cycles with stray start pulses
  task automatic run(input int g, input int hold, input string tag, output int got);
    int exp = model(g);
    int lat;
    int naddr = 0;
    @(negedge clk); start[g] = 1'b1; res_rdy[g] = 1'b0;
    @(negedge clk); start[g] = 1'b0; lat = 1;
    while (!res_vld[g] && lat < 60) begin
      if (rd_en[g]) begin
        chk({tag, " rd_addr"}, int'(rd_addr[g]), naddr);
        naddr++;
      end
      @(negedge clk); lat++;
    end
    chk({tag, " latency"}, lat, vec_len(g) + 3);
    chk({tag, " reads"}, naddr, vec_len(g));
    chk({tag, " res"}, int'(res[g]), exp);
    got = int'(res[g]);
    for (int c = 0; c < hold; c++) begin
      start[g] = 1'b1;
      #1;
      chk({tag, " hold vld"}, int'(res_vld[g]), 1);
      chk({tag, " hold res"}, int'(res[g]), exp);
      chk({tag, " hold busy"}, int'(busy[g]), 1);
      chk({tag, " hold done"}, int'(done[g]), 0);
      @(negedge clk);
    end
    start[g] = 1'b0; res_rdy[g] = 1'b1;
    #1;
    chk({tag, " done"}, int'(done[g]), 1);
    @(negedge clk); res_rdy[g] = 1'b0;
    #1;
    chk({tag, " idle busy"}, int'(busy[g]), 0);
    chk({tag, " idle vld"}, int'(res_vld[g]), 0);
    @(negedge clk); #1;
    chk({tag, " no requeue"}, int'(busy[g]), 0);
  endtask

  int got;
  int r1;
  int gap;

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin start[g] = 1'b0; res_rdy[g] = 1'b0; end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst busy", int'(busy[g]), 0);
      chk("rst done", int'(done[g]), 0);
      chk("rst rd_en", int'(rd_en[g]), 0);
      chk("rst rd_addr", int'(rd_addr[g]), 0);
      chk("rst res", int'(res[g]), 0);
      chk("rst res_vld", int'(res_vld[g]), 0);
      chk("rst clr_n", int'(clr_n[g]), 0);
    end
    rst = 1'b0;

    fill(0, 0); run(0, 0, "t1", got); chk("t1 sum", got, 10);
    fill(1, 1); run(1, 0, "t2 pos", got); chk("t2 pos sat", got, 127);
    fill(1, 2); run(1, 1, "t2 neg", got); chk("t2 neg sat", got, -128);
    fill(1, 3); run(1, 0, "t3", got); chk("t3 floor", got, -1);
    fill(1, 9); run(1, 5, "t4", got);

    for (int i = 0; i < 6; i++) begin
      fill(i % 2, 9);
      run(i % 2, int'($urandom_range(0, 3)), "rand", got);
    end

    // reset while streaming
    fill(0, 0);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("t5 busy", int'(busy[0]), 0);
    chk("t5 rd_en", int'(rd_en[0]), 0);
    chk("t5 res_vld", int'(res_vld[0]), 0);
    chk("t5 clr_n", int'(clr_n[0]), 0);
    run(0, 0, "t5 rerun", got); chk("t5 rerun sum", got, 10);

    // start held high, consumer always ready
    fill(0, 9);
    @(negedge clk); start[0] = 1'b1; res_rdy[0] = 1'b1;
    #1;
    for (int c = 0; c < 40 && !done[0]; c++) begin @(negedge clk); #1; end
    chk("t6 done1", int'(done[0]), 1);
    r1 = int'(res[0]);
    chk("t6 res1", r1, model(0));
    @(negedge clk); #1;
    chk("t6 idle gap", int'(busy[0]), 0);
    @(negedge clk); #1;
    chk("t6 clear busy", int'(busy[0]), 1);
    chk("t6 clear clr_n", int'(clr_n[0]), 0);
    chk("t6 clear rd_en", int'(rd_en[0]), 1);
    gap = 2;
    while (!done[0] && gap < 40) begin @(negedge clk); #1; gap++; end
    chk("t6 period", gap, VL0 + 4);
    chk("t6 res2", int'(res[0]), r1);
    start[0] = 1'b0;
    @(negedge clk); res_rdy[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
